// File: rtl/alu_latch_pkg.sv
// Shared definitions for the ALU result latch family: default widths, flag bit positions
// and the packed entry type used by the result queue.
package alu_latch_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_FLAG_W = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] data;
        logic [ALU_FLAG_W-1:0] flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_queue_mem.sv
// Storage array for the ALU result queue: one synchronous write port and one
// combinational read port. Contents are deliberately left unreset.
module alu_result_queue_mem #(
    parameter int ENTRY_W = 20,
    parameter int DEPTH   = 4,
    parameter int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               wrEn_i,
    input  logic [PTR_W-1:0]   wrAddr_i,
    input  logic [ENTRY_W-1:0] wrData_i,
    input  logic [PTR_W-1:0]   rdAddr_i,
    output logic [ENTRY_W-1:0] rdData_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/alu_result_queue.sv
// FIFO of ALU results with flags, driving the oldest entry onto the shared tri-state bus.
// Optional macro ALU_QUEUE_BYPASS_EN forwards a push straight to the bus when the queue is empty.
module alu_result_queue
    import alu_latch_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int FLAG_W = ALU_FLAG_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] flags,
    input  logic              ALU_latch_in,
    input  logic              ALU_latch_out,
    input  logic              clear_err,
    output logic [DATA_W-1:0] out,
    output logic [FLAG_W-1:0] flags_out,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_W + FLAG_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [FLAG_W-1:0] flags;
    } entry_t;

    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] outData_q, outData_d;
    logic              driveEn_q, driveEn_d;
    logic [FLAG_W-1:0] flagsOut_q, flagsOut_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic   isFull, isEmpty;
    logic   popValid, pushValid, bypass;
    logic   overflowEvt, underflowEvt;
    entry_t wrEntry, rdEntry;

    assign isFull  = (count_q == CNT_W'(DEPTH));
    assign isEmpty = (count_q == '0);

    assign wrEntry.data  = alu_result;
    assign wrEntry.flags = flags;

`ifdef ALU_QUEUE_BYPASS_EN
    assign bypass = ALU_latch_in && ALU_latch_out && isEmpty;
`else
    assign bypass = 1'b0;
`endif

    alu_result_queue_mem #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH),
        .PTR_W   (PTR_W)
    ) u_mem (
        .clock    (clock),
        .wrEn_i   (pushValid),
        .wrAddr_i (wrPtr_q),
        .wrData_i (wrEntry),
        .rdAddr_i (rdPtr_q),
        .rdData_o (rdEntry)
    );

    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    always_comb begin
        popValid     = ALU_latch_out && !isEmpty;
        pushValid    = ALU_latch_in && !bypass && (!isFull || popValid);
        overflowEvt  = ALU_latch_in && !bypass && !pushValid;
        underflowEvt = ALU_latch_out && isEmpty && !bypass;

        wrPtr_d = wrPtr_q + PTR_W'(pushValid);
        rdPtr_d = rdPtr_q + PTR_W'(popValid);
        count_d = count_q + CNT_W'(pushValid) - CNT_W'(popValid);

        driveEn_d  = popValid || bypass;
        outData_d  = outData_q;
        flagsOut_d = flagsOut_q;
        if (bypass) begin
            outData_d  = alu_result;
            flagsOut_d = flags;
        end else if (popValid) begin
            outData_d  = rdEntry.data;
            flagsOut_d = rdEntry.flags;
        end

        overflow_d  = (overflow_q && !clear_err) || overflowEvt;
        underflow_d = (underflow_q && !clear_err) || underflowEvt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            outData_q   <= '0;
            driveEn_q   <= 1'b0;
            flagsOut_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            outData_q   <= outData_d;
            driveEn_q   <= driveEn_d;
            flagsOut_q  <= flagsOut_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign out       = driveEn_q ? outData_q : {DATA_W{1'bz}};
    assign flags_out = flagsOut_q;
    assign full      = isFull;
    assign empty     = isEmpty;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench for alu_result_queue: scenario tasks against a queue-based scoreboard.
// Honours ALU_QUEUE_BYPASS_EN when the design is built with it.
module tb_alu_result_queue;
    import alu_latch_pkg::*;

    localparam int DATA_W = 16;
    localparam int FLAG_W = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clock;
    logic              reset;
    logic [DATA_W-1:0] aluResult;
    logic [FLAG_W-1:0] aluFlags;
    logic              latchIn;
    logic              latchOut;
    logic              clearErr;
    wire  [DATA_W-1:0] busOut;
    logic [FLAG_W-1:0] flagsOut;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    int nChecks;
    int nFails;

    alu_entry_t        expQ[$];
    logic [DATA_W-1:0] expOut;
    logic              expDrive;
    logic [FLAG_W-1:0] expFlags;
    logic              expOver;
    logic              expUnder;
    logic [DATA_W-1:0] busZ;

    alu_result_queue #(
        .DATA_W (DATA_W),
        .FLAG_W (FLAG_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .alu_result    (aluResult),
        .flags         (aluFlags),
        .ALU_latch_in  (latchIn),
        .ALU_latch_out (latchOut),
        .clear_err     (clearErr),
        .out           (busOut),
        .flags_out     (flagsOut),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] expBus();
        return expDrive ? expOut : busZ;
    endfunction

    // Drives one cycle of stimulus, updates the scoreboard, and returns 1 ns after the edge.
    task automatic applyStimulus(input bit push, input bit pop, input bit clr,
                                 input logic [DATA_W-1:0] d, input logic [FLAG_W-1:0] f);
        int         sizeBefore;
        bit         popOk, pushOk, byp;
        alu_entry_t e;
        sizeBefore = expQ.size();
        byp = 1'b0;
`ifdef ALU_QUEUE_BYPASS_EN
        byp = push && pop && (sizeBefore == 0);
`endif
        popOk  = pop && (sizeBefore > 0);
        pushOk = push && !byp && ((sizeBefore < DEPTH) || popOk);
        if (popOk) begin
            e = expQ.pop_front();
            expOut   = e.data;
            expFlags = e.flags;
            expDrive = 1'b1;
        end else if (byp) begin
            expOut   = d;
            expFlags = f;
            expDrive = 1'b1;
        end else begin
            expDrive = 1'b0;
        end
        if (pushOk) begin
            e.data  = d;
            e.flags = f;
            expQ.push_back(e);
        end
        expOver  = (expOver && !clr) || (push && !byp && !pushOk);
        expUnder = (expUnder && !clr) || (pop && !byp && (sizeBefore == 0));

        aluResult = d;
        aluFlags  = f;
        latchIn   = push;
        latchOut  = pop;
        clearErr  = clr;
        @(posedge clock);
        #1;
        latchIn  = 1'b0;
        latchOut = 1'b0;
        clearErr = 1'b0;
    endtask

    task automatic test_reset();
        nChecks++;
        if (busOut !== busZ) begin
            nFails++;
            $display("[TB] FAIL reset_out: got %h expected Z", busOut);
        end
        nChecks++;
        if (flagsOut !== 4'h0) begin
            nFails++;
            $display("[TB] FAIL reset_flags: got %h expected 0", flagsOut);
        end
        nChecks++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== '0) begin
            nFails++;
            $display("[TB] FAIL reset_status: empty=%b full=%b count=%0d expected 1 0 0", empty, full, count);
        end
        nChecks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_errs: ovf=%b unf=%b expected 0 0", overflow, underflow);
        end
    endtask

    task automatic test_fifo_order();
        logic [DATA_W-1:0] wantData[3];
        logic [FLAG_W-1:0] wantFlags[3];
        wantData  = '{16'h1111, 16'h2222, 16'h3333};
        wantFlags = '{4'h1, 4'h2, 4'h4};
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, wantData[i], wantFlags[i]);
        nChecks++;
        if (count !== CNT_W'(3) || empty !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL fifo_count: count=%0d empty=%b expected 3 0", count, empty);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
            nChecks++;
            if (busOut !== wantData[i] || flagsOut !== wantFlags[i]) begin
                nFails++;
                $display("[TB] FAIL fifo_pop%0d: got %h/%h expected %h/%h", i, busOut, flagsOut, wantData[i], wantFlags[i]);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        nChecks++;
        if (busOut !== busZ || empty !== 1'b1 || flagsOut !== 4'h4) begin
            nFails++;
            $display("[TB] FAIL fifo_idle: out=%h empty=%b flags=%h expected Z 1 4", busOut, empty, flagsOut);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h1000 + 16'(i), 4'(i + 8));
        nChecks++;
        if (full !== 1'b1 || overflow !== 1'b1 || count !== CNT_W'(DEPTH)) begin
            nFails++;
            $display("[TB] FAIL ovf_status: full=%b ovf=%b count=%0d expected 1 1 4", full, overflow, count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
            nChecks++;
            if (busOut !== expBus() || flagsOut !== expFlags || busOut !== 16'h1000 + 16'(i)) begin
                nFails++;
                $display("[TB] FAIL ovf_drain%0d: got %h/%h expected %h/%h", i, busOut, flagsOut, expBus(), expFlags);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
        nChecks++;
        if (overflow !== 1'b0 || empty !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL ovf_clear: ovf=%b empty=%b expected 0 1", overflow, empty);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'hB000 + 16'(i), 4'(i));
        applyStimulus(1'b1, 1'b1, 1'b0, 16'hAAAA, 4'hA);
        nChecks++;
        if (count !== CNT_W'(DEPTH) || overflow !== 1'b0 || busOut !== 16'hB000) begin
            nFails++;
            $display("[TB] FAIL b2b_full: count=%0d ovf=%b out=%h expected 4 0 b000", count, overflow, busOut);
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
            nChecks++;
            if (busOut !== expBus() || flagsOut !== expFlags) begin
                nFails++;
                $display("[TB] FAIL b2b_drain%0d: got %h/%h expected %h/%h", i, busOut, flagsOut, expBus(), expFlags);
            end
        end
        nChecks++;
        if (busOut !== 16'hAAAA || flagsOut !== 4'hA || empty !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL b2b_last: got %h/%h empty=%b expected aaaa/a 1", busOut, flagsOut, empty);
        end
    endtask

    task automatic test_underflow();
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
        nChecks++;
        if (underflow !== 1'b1 || busOut !== busZ || flagsOut !== 4'hA) begin
            nFails++;
            $display("[TB] FAIL unf_pop: unf=%b out=%h flags=%h expected 1 Z a", underflow, busOut, flagsOut);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, '0, '0);
        nChecks++;
        if (underflow !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL unf_clear_race: unf=%b expected 1", underflow);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
        nChecks++;
        if (underflow !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL unf_clear: unf=%b expected 0", underflow);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h5A5A, 4'h5);
        nChecks++;
        if (busOut !== expBus() || count !== CNT_W'(expQ.size()) || underflow !== expUnder) begin
            nFails++;
            $display("[TB] FAIL empty_pushpop: out=%h count=%0d unf=%b expected %h %0d %b",
                     busOut, count, underflow, expBus(), expQ.size(), expUnder);
        end
`ifdef ALU_QUEUE_BYPASS_EN
        nChecks++;
        if (busOut !== 16'h5A5A || flagsOut !== 4'h5 || count !== '0) begin
            nFails++;
            $display("[TB] FAIL bypass: got %h/%h count=%0d expected 5a5a/5 0", busOut, flagsOut, count);
        end
`else
        applyStimulus(1'b0, 1'b1, 1'b1, '0, '0);
        nChecks++;
        if (busOut !== 16'h5A5A || flagsOut !== 4'h5 || empty !== 1'b1 || underflow !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL stored_pushpop: got %h/%h empty=%b unf=%b expected 5a5a/5 1 0",
                     busOut, flagsOut, empty, underflow);
        end
`endif
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hC001, 4'h3);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hC002, 4'h6);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'hC003, 4'h7);
        nChecks++;
        if (busOut !== 16'hC001 || count !== CNT_W'(2)) begin
            nFails++;
            $display("[TB] FAIL pre_reset: out=%h count=%0d expected c001 2", busOut, count);
        end
        #3;
        reset = 1'b0;
        #1;
        expQ.delete();
        expDrive = 1'b0;
        expFlags = '0;
        expOver  = 1'b0;
        expUnder = 1'b0;
        nChecks++;
        if (busOut !== busZ || count !== '0 || empty !== 1'b1 || flagsOut !== 4'h0) begin
            nFails++;
            $display("[TB] FAIL async_reset: out=%h count=%0d empty=%b flags=%h expected Z 0 1 0",
                     busOut, count, empty, flagsOut);
        end
        #2;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
        nChecks++;
        if (underflow !== 1'b1 || busOut !== busZ) begin
            nFails++;
            $display("[TB] FAIL post_reset_pop: unf=%b out=%h expected 1 Z", underflow, busOut);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        nChecks   = 0;
        nFails    = 0;
        busZ      = 'z;
        reset     = 1'b0;
        aluResult = '0;
        aluFlags  = '0;
        latchIn   = 1'b0;
        latchOut  = 1'b0;
        clearErr  = 1'b0;
        expOut    = '0;
        expDrive  = 1'b0;
        expFlags  = '0;
        expOver   = 1'b0;
        expUnder  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        test_fifo_order();
        test_overflow();
        test_back_to_back();
        test_underflow();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
